// File: rtl/cache_fill_fsm_if.sv
// Miss request, memory read handshake and cache-array write bundle for cache_fill_fsm.
// master = fill sequencer side, slave = requester/memory/array side.
interface cache_fill_fsm_if;
   logic        miss_detected;
   logic [15:0] miss_address;
   logic        memory_data_valid;
   logic [15:0] memory_data;
   logic        memory_read_en;
   logic [15:0] memory_address;
   logic        fsm_busy;
   logic [63:0] set_enable;
   logic [7:0]  word_enable;
   logic        write_data_array;
   logic [15:0] fill_data;
   logic        write_tag_array;
   logic [7:0]  tag_out;
   logic        fill_done;
   logic        fill_error;

   modport master (
      input  miss_detected, miss_address, memory_data_valid, memory_data,
      output memory_read_en, memory_address, fsm_busy, set_enable, word_enable,
             write_data_array, fill_data, write_tag_array, tag_out, fill_done, fill_error
   );

   modport slave (
      output miss_detected, miss_address, memory_data_valid, memory_data,
      input  memory_read_en, memory_address, fsm_busy, set_enable, word_enable,
             write_data_array, fill_data, write_tag_array, tag_out, fill_done, fill_error
   );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache line fill sequencer: issues 8 word reads for a missed line, writes returning words, then the tag.
// Optional fill watchdog is compiled in when CACHE_FILL_TIMEOUT_EN is defined.
module cache_fill_fsm #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input logic              clk,
   input logic              rst_n,
   cache_fill_fsm_if.master bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, META = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [11:0] line_q, line_d;
   logic [2:0]  issue_cnt_q, issue_cnt_d;
   logic        issue_done_q, issue_done_d;
   logic [2:0]  recv_cnt_q, recv_cnt_d;
   logic        recv_done_q, recv_done_d;
   logic        in_fill, in_meta, data_write;

   assign in_fill    = (state_q == FILL);
   assign in_meta    = (state_q == META);
   // Returning words go straight to the data array in the cycle they arrive.
   assign data_write = in_fill && bus.memory_data_valid && !recv_done_q;

`ifdef CACHE_FILL_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            fill_error_q, fill_error_d;
`endif

   always_comb begin
      state_d      = state_q;
      line_d       = line_q;
      issue_cnt_d  = issue_cnt_q;
      issue_done_d = issue_done_q;
      recv_cnt_d   = recv_cnt_q;
      recv_done_d  = recv_done_q;
`ifdef CACHE_FILL_TIMEOUT_EN
      to_cnt_d     = to_cnt_q;
      fill_error_d = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.miss_detected) begin
               line_d       = bus.miss_address[15:4];
               issue_cnt_d  = 3'd0;
               issue_done_d = 1'b0;
               recv_cnt_d   = 3'd0;
               recv_done_d  = 1'b0;
               state_d      = FILL;
`ifdef CACHE_FILL_TIMEOUT_EN
               to_cnt_d     = '0;
`endif
            end
         end
         FILL: begin
            if (!issue_done_q) begin
               issue_cnt_d  = issue_cnt_q + 3'd1;
               issue_done_d = (issue_cnt_q == 3'd7);
            end
            if (data_write) begin
               recv_cnt_d = recv_cnt_q + 3'd1;
               if (recv_cnt_q == 3'd7) begin
                  recv_done_d = 1'b1;
                  state_d     = META;
               end
            end
`ifdef CACHE_FILL_TIMEOUT_EN
            // A fill that completes on the last allowed cycle still wins over the watchdog.
            if (state_d != META) begin
               if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                  state_d      = IDLE;
                  fill_error_d = 1'b1;
               end else begin
                  to_cnt_d = to_cnt_q + TO_W'(1);
               end
            end
`endif
         end
         META:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         line_q       <= '0;
         issue_cnt_q  <= '0;
         issue_done_q <= 1'b0;
         recv_cnt_q   <= '0;
         recv_done_q  <= 1'b0;
`ifdef CACHE_FILL_TIMEOUT_EN
         to_cnt_q     <= '0;
         fill_error_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         line_q       <= line_d;
         issue_cnt_q  <= issue_cnt_d;
         issue_done_q <= issue_done_d;
         recv_cnt_q   <= recv_cnt_d;
         recv_done_q  <= recv_done_d;
`ifdef CACHE_FILL_TIMEOUT_EN
         to_cnt_q     <= to_cnt_d;
         fill_error_q <= fill_error_d;
`endif
      end
   end

   generate
      for (genvar gi = 0; gi < 64; gi++) begin : g_set
         assign bus.set_enable[gi] = !(state_q == IDLE) && (line_q[5:0] == 6'(gi));
      end
      for (genvar gi = 0; gi < 8; gi++) begin : g_word
         assign bus.word_enable[gi] = data_write && (recv_cnt_q == 3'(gi));
      end
   endgenerate

   assign bus.memory_read_en   = in_fill && !issue_done_q;
   assign bus.memory_address   = bus.memory_read_en ? {line_q, issue_cnt_q, 1'b0} : 16'h0000;
   assign bus.fsm_busy         = (state_q != IDLE);
   assign bus.write_data_array = data_write;
   assign bus.fill_data        = data_write ? bus.memory_data : 16'h0000;
   assign bus.write_tag_array  = in_meta;
   assign bus.fill_done        = in_meta;
   assign bus.tag_out          = in_meta ? {1'b1, 1'b0, line_q[11:6]} : 8'h00;

`ifdef CACHE_FILL_TIMEOUT_EN
   assign bus.fill_error = fill_error_q;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES != 0);
   assign bus.fill_error = 1'b0;
`endif

   logic unused_offset;
   assign unused_offset = ^bus.miss_address[3:0];
endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: watchdog limit in cycles, used only when CACHE_FILL_TIMEOUT_EN is defined.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1  synchronous active-low reset.
REQ-004 SHALL have port miss_detected  in  1  cache miss request, level, sampled in IDLE only.
REQ-005 SHALL have port miss_address  in  16  byte address of the miss: tag [15:10], index [9:4], offset [3:0].
REQ-006 SHALL have port memory_data_valid  in  1  memory returns one word this cycle.
REQ-007 SHALL have port memory_data  in  16  returned word.
REQ-008 SHALL have port memory_read_en  out  1  memory read request this cycle.
REQ-009 SHALL have port memory_address  out  16  word address of the request.
REQ-010 SHALL have port fsm_busy  out  1  high in any state other than IDLE.
REQ-011 SHALL have port set_enable  out  64  one-hot set select to both way arrays.
REQ-012 SHALL have port word_enable  out  8  one-hot word select to the data way array.
REQ-013 SHALL have port write_data_array  out  1  data way array wen.
REQ-014 SHALL have port fill_data  out  16  data way array data_in.
REQ-015 SHALL have port write_tag_array  out  1  metadata way array wen.
REQ-016 SHALL have port tag_out  out  8  metadata data_in = {1'b1 valid, 1'b0 LRU, tag[5:0]}.
REQ-017 SHALL have port fill_done  out  1  one-cycle completion pulse.
REQ-018 SHALL have port fill_error  out  1  one-cycle timeout pulse.

Function
REQ-019 SHALL implement states IDLE, FILL and META.
REQ-020 IDLE: when miss_detected=1, SHALL latch miss_address[15:4], clear issue_cnt and recv_cnt (3 bits each plus a done flag), and go to FILL the next cycle.
REQ-021 FILL: while fewer than 8 requests have been issued, SHALL assert memory_read_en with memory_address = {line, issue_cnt, 1'b0}; issue_cnt increments each cycle; 8 consecutive requests total.
REQ-022 FILL: on memory_data_valid, SHALL assert write_data_array in the same cycle, with word_enable = one-hot(recv_cnt) and fill_data = memory_data; recv_cnt then increments. This path is combinational with zero latency.
REQ-023 FILL to META SHALL occur on the cycle the 8th word is written; META is always exactly one cycle.
REQ-024 META: SHALL assert write_tag_array=1 and fill_done=1 with tag_out valid, then go to IDLE; a new miss is accepted no earlier than the following cycle.
REQ-025 set_enable SHALL be one-hot(latched index) in FILL and META, and all-zero in IDLE; word_enable SHALL be zero except in data-write cycles.
REQ-026 memory_data_valid in IDLE or META SHALL be ignored: no array write.
REQ-027 Deassertion of miss_detected or a change of miss_address during FILL or META SHALL be ignored; the latched line completes.
REQ-028 Words returning while requests are still being issued SHALL be accepted; the bench memory returns words 4 cycles after request.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force IDLE and clear all counters; every output SHALL be 0 (set_enable and word_enable all-zero).
REQ-030 Reset in mid-fill SHALL abort with no further array writes and no fill_done.

Configuration
REQ-031 With CACHE_FILL_TIMEOUT_EN defined: a cycle counter SHALL start at FILL entry. If FILL has lasted TIMEOUT_CYCLES cycles without reaching META, the block SHALL go to IDLE, pulse fill_error for one cycle and skip the tag write.
REQ-032 Without CACHE_FILL_TIMEOUT_EN: no counter; fill_error SHALL be tied 0 and FILL SHALL wait indefinitely.

Verification
REQ-033 Miss at 0x1234, 4-cycle memory -> addresses 0x1230..0x123E issued in 8 consecutive cycles; data writes use set_enable bit 35, word_enable 0x01..0x80 in order; META tag_out=0x84; fill_done 1 cycle.
REQ-034 Memory returns words with 2-cycle gaps -> exactly 8 data writes, one per valid; META immediately follows the 8th.
REQ-035 miss_address changes to 0xFFF0 during FILL -> all writes still target set 35 and tag_out stays 0x84.
REQ-036 rst_n=0 after the 3rd word -> next cycle all outputs 0, no fill_done; a fresh miss at 0x0000 fills set 0 normally.
REQ-037 memory_data_valid pulsed in IDLE -> write_data_array stays 0.
REQ-038 With CACHE_FILL_TIMEOUT_EN and TIMEOUT_CYCLES=16, memory returns only 5 words -> fill_error pulse at cycle 16 after FILL entry, no write_tag_array, back to IDLE.
